// File: rtl/ofm_pkg.sv
// Shared types and helpers for the output-feature-map drain path: FSM state,
// beat-count derivation and the shift/ReLU/saturate requantizer.
package ofm_pkg;

  localparam int CU_NUM_DEF   = 32;
  localparam int ACC_W_DEF    = 32;
  localparam int BUS_SIZE_DEF = 8;
  localparam int OBUF_NUM_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EMIT = 2'd2
  } ofm_state_e;

  function automatic int beat_num(input int cu_num, input int bus_size);
    return cu_num / bus_size;
  endfunction

  // Shifts of 31 leave only the sign, so every result lands at 0 after ReLU.
  function automatic logic [7:0] requant8(input logic signed [31:0] acc,
                                          input logic [4:0] shift);
    logic signed [31:0] v;
    v = acc >>> shift;
    if (v <= 0)
      return 8'd0;
    else if (v > 32'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/ofm_compress_store.sv
// Sparse map, packed non-zero byte store and non-zero counter for one drain
// pass; each non-zero byte is written at the current count, then the count advances.
module ofm_compress_store
  import ofm_pkg::*;
#(
  parameter int CU_NUM = CU_NUM_DEF,
  localparam int CU_W  = $clog2(CU_NUM)
) (
  input  logic                  clk_r,
  input  logic                  rst_r,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [CU_W-1:0]       idx_i,
  input  logic [7:0]            q_i,
  output logic [CU_NUM-1:0]     map_o,
  output logic [CU_NUM*8-1:0]   bytes_o,
  output logic [CU_W:0]         nnz_o
);

  logic [CU_NUM-1:0]   map_q,   map_d;
  logic [CU_NUM*8-1:0] bytes_q, bytes_d;
  logic [CU_W:0]       nnz_q,   nnz_d;

  always_comb begin
    map_d   = map_q;
    bytes_d = bytes_q;
    nnz_d   = nnz_q;
    if (clr_i) begin
      map_d   = '0;
      bytes_d = '0;
      nnz_d   = '0;
    end else if (wr_en_i) begin
      map_d[idx_i] = (q_i != 8'd0);
      if (q_i != 8'd0) begin
        bytes_d[{nnz_q[CU_W-1:0], 3'b000} +: 8] = q_i;
        nnz_d = nnz_q + (CU_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      map_q   <= '0;
      bytes_q <= '0;
      nnz_q   <= '0;
    end else begin
      map_q   <= map_d;
      bytes_q <= bytes_d;
      nnz_q   <= nnz_d;
    end
  end

  assign map_o   = map_q;
  assign bytes_o = bytes_q;
  assign nnz_o   = nnz_q;

endmodule

// File: rtl/ofm_sparse_packer.sv
// Drains one accumulator per compute unit, requantizes to u8 and emits the
// pass as sparse-map beats plus a globally packed non-zero byte stream.
//
// state   | meaning
// ST_IDLE | waiting for start_i
// ST_READ | issuing cu_sel_o and sampling accumulators one cycle later
// ST_EMIT | presenting beats until the last one is accepted
module ofm_sparse_packer
  import ofm_pkg::*;
#(
  parameter int CU_NUM   = CU_NUM_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int BUS_SIZE = BUS_SIZE_DEF,
  parameter int OBUF_NUM = OBUF_NUM_DEF,
  localparam int CU_W     = $clog2(CU_NUM),
  localparam int OB_W     = $clog2(OBUF_NUM),
  localparam int BEAT_NUM = beat_num(CU_NUM, BUS_SIZE),
  localparam int BC_W     = $clog2(BEAT_NUM)
) (
  input  logic                  clk_r,
  input  logic                  rst_r,
  input  logic                  start_i,
  input  logic [OB_W-1:0]       buf_idx_i,
  input  logic [4:0]            shift_i,
  output logic [CU_W-1:0]       cu_sel_o,
  output logic [OB_W-1:0]       obuf_sel_o,
  input  logic [ACC_W-1:0]      obuf_dat_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [BC_W-1:0]       wr_count_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic [CU_W:0]         nnz_count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o
);

  ofm_state_e      state_q, state_d;
  logic [CU_W-1:0] cu_sel_q, cu_sel_d;
  logic            iss_q, iss_d;
  logic            rd_vld_q, rd_vld_d;
  logic [CU_W-1:0] rd_idx_q, rd_idx_d;
  logic [OB_W-1:0] buf_q, buf_d;
  logic [4:0]      shift_q, shift_d;
  logic [BC_W-1:0] beat_q, beat_d;
  logic            clr, wr_en, done;

  logic signed [31:0]  acc_ext;
  logic [7:0]          q_val;
  logic [CU_NUM-1:0]   map_w;
  logic [CU_NUM*8-1:0] bytes_w;
  logic [CU_W:0]       nnz_w;

  assign acc_ext = 32'($signed(obuf_dat_i));
  assign q_val   = requant8(acc_ext, shift_q);

  always_comb begin
    state_d  = state_q;
    cu_sel_d = cu_sel_q;
    iss_d    = iss_q;
    rd_vld_d = iss_q;
    rd_idx_d = cu_sel_q;
    buf_d    = buf_q;
    shift_d  = shift_q;
    beat_d   = beat_q;
    clr      = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_READ;
          buf_d    = buf_idx_i;
          shift_d  = shift_i;
          cu_sel_d = '0;
          iss_d    = 1'b1;
          beat_d   = '0;
          clr      = 1'b1;
        end
      end
      ST_READ: begin
        if (iss_q) begin
          if (cu_sel_q == CU_W'(CU_NUM-1))
            iss_d = 1'b0;
          else
            cu_sel_d = cu_sel_q + CU_W'(1);
        end
        // Read data trails the select by one cycle; rd_idx_q tracks which element it is.
        if (rd_vld_q) begin
          wr_en = 1'b1;
          if (rd_idx_q == CU_W'(CU_NUM-1))
            state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (wr_ready_i) begin
          if (beat_q == BC_W'(BEAT_NUM-1)) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            beat_d = beat_q + BC_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      state_q  <= ST_IDLE;
      cu_sel_q <= '0;
      iss_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      buf_q    <= '0;
      shift_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      cu_sel_q <= cu_sel_d;
      iss_q    <= iss_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      buf_q    <= buf_d;
      shift_q  <= shift_d;
      beat_q   <= beat_d;
    end
  end

  ofm_compress_store #(
    .CU_NUM (CU_NUM)
  ) u_store (
    .clk_r   (clk_r),
    .rst_r   (rst_r),
    .clr_i   (clr),
    .wr_en_i (wr_en),
    .idx_i   (rd_idx_q),
    .q_i     (q_val),
    .map_o   (map_w),
    .bytes_o (bytes_w),
    .nnz_o   (nnz_w)
  );

  // Bytes at or beyond the non-zero count always read as zero.
  always_comb begin
    wr_sparsemap_o    = '0;
    wr_nonzero_data_o = '0;
    for (int j = 0; j < BUS_SIZE; j++) begin
      wr_sparsemap_o[j] = map_w[int'(beat_q)*BUS_SIZE + j];
      if ((int'(beat_q)*BUS_SIZE + j) < int'(nnz_w))
        wr_nonzero_data_o[j*8 +: 8] = bytes_w[(int'(beat_q)*BUS_SIZE + j)*8 +: 8];
    end
  end

  assign cu_sel_o    = cu_sel_q;
  assign obuf_sel_o  = buf_q;
  assign wr_valid_o  = (state_q == ST_EMIT);
  assign wr_count_o  = beat_q;
  assign nnz_count_o = nnz_w;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done;
  assign overrun_o   = start_i && (state_q != ST_IDLE);

endmodule

// File: tb/tb_ofm_sparse_packer.sv
// Self-checking bench: table of drain passes with a beat scoreboard, plus
// hand-written reset-mid-pass sequence.
`timescale 1ns/1ps
module tb_ofm_sparse_packer;
  localparam int CU  = 32;
  localparam int BUS = 8;
  localparam int NB  = 4;
  localparam int OBN = 4;

  typedef struct {
    int         pat;
    logic [1:0] bufi;
    logic [4:0] sh;
    int         stall_beat;
    int         stall_len;
    bit         ovr;
    int         exp_nnz;
    int         exp_done;
    bit         chk_map0;
    logic [7:0] exp_map0;
  } vec_t;

  typedef struct {
    logic [1:0]  cnt;
    logic [7:0]  map;
    logic [63:0] data;
  } beat_t;

  logic        clk_r, rst_r, start_i, wr_ready_i;
  logic [1:0]  buf_idx_i;
  logic [4:0]  shift_i;
  logic [4:0]  cu_sel_o;
  logic [1:0]  obuf_sel_o;
  logic [31:0] obuf_dat_i;
  logic        wr_valid_o;
  logic [1:0]  wr_count_o;
  logic [7:0]  wr_sparsemap_o;
  logic [63:0] wr_nonzero_data_o;
  logic [5:0]  nnz_count_o;
  logic        busy_o, done_o, overrun_o;

  ofm_sparse_packer dut (
    .clk_r             (clk_r),
    .rst_r             (rst_r),
    .start_i           (start_i),
    .buf_idx_i         (buf_idx_i),
    .shift_i           (shift_i),
    .cu_sel_o          (cu_sel_o),
    .obuf_sel_o        (obuf_sel_o),
    .obuf_dat_i        (obuf_dat_i),
    .wr_valid_o        (wr_valid_o),
    .wr_ready_i        (wr_ready_i),
    .wr_count_o        (wr_count_o),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .nnz_count_o       (nnz_count_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .overrun_o         (overrun_o)
  );

  initial clk_r = 1'b0;
  always #5 clk_r = ~clk_r;

  // Output buffer model: synchronous read, data one cycle after the select.
  logic [31:0] mem [OBN][CU];
  logic [4:0]  sel_d1;
  logic [1:0]  bsel_d1;
  always @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      sel_d1  <= '0;
      bsel_d1 <= '0;
    end else begin
      sel_d1  <= cu_sel_o;
      bsel_d1 <= obuf_sel_o;
    end
  end
  assign obuf_dat_i = mem[bsel_d1][sel_d1];

  int    checks = 0;
  int    errors = 0;
  int    ovr_cnt = 0;
  beat_t sb_q[$];
  beat_t exp_b, held;
  logic  stall_prev = 1'b0;
  vec_t  vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mdl(input logic [31:0] a, input int sh);
    longint v;
    v = longint'($signed(a));
    v = v >>> sh;
    if (v <= 0) return 8'd0;
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  task automatic fill(input int pat, input logic [1:0] b);
    logic [31:0] bl [8];
    bl = '{32'd255, 32'd256, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd254};
    for (int o = 0; o < OBN; o++)
      for (int n = 0; n < CU; n++) mem[o][n] = $urandom;
    for (int n = 0; n < CU; n++) begin
      case (pat)
        0: mem[b][n] = 32'h0000_0100;
        1: mem[b][n] = (n % 2 == 0) ? 32'd40 : 32'hFFFF_FFD8;
        2: mem[b][n] = (n == 31) ? 32'd7 : 32'd0;
        3: mem[b][n] = 32'($urandom_range(1200, 0)) - 32'd400;
        4: mem[b][n] = $urandom;
        default: mem[b][n] = bl[n % 8];
      endcase
    end
  endtask

  task automatic push_expect(input logic [1:0] b, input logic [4:0] sh, output int nnz);
    logic [7:0]    bytes [CU];
    logic [CU-1:0] map;
    logic [7:0]    q;
    beat_t         bt;
    nnz = 0;
    map = '0;
    for (int j = 0; j < CU; j++) bytes[j] = 8'd0;
    for (int n = 0; n < CU; n++) begin
      q = mdl(mem[b][n], int'(sh));
      if (q != 8'd0) begin
        map[n] = 1'b1;
        bytes[nnz] = q;
        nnz++;
      end
    end
    for (int k = 0; k < NB; k++) begin
      bt.cnt = 2'(k);
      bt.map = map[k*BUS +: BUS];
      for (int j = 0; j < BUS; j++) bt.data[j*8 +: 8] = bytes[k*BUS + j];
      sb_q.push_back(bt);
    end
  endtask

  // Scoreboard monitor: pops on every accepted beat, checks hold while stalled.
  always @(negedge clk_r) begin
    if (!rst_r) begin
      stall_prev = 1'b0;
    end else begin
      if (overrun_o) ovr_cnt++;
      if (stall_prev) begin
        chk("hold_valid", 64'(wr_valid_o), 64'd1);
        chk("hold_map", 64'(wr_sparsemap_o), 64'(held.map));
        chk("hold_data", wr_nonzero_data_o, held.data);
        chk("hold_cnt", 64'(wr_count_o), 64'(held.cnt));
      end
      stall_prev = 1'b0;
      if (wr_valid_o) begin
        if (wr_ready_i) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_beat: got beat %0d expected none", wr_count_o);
          end else begin
            exp_b = sb_q.pop_front();
            chk("beat_cnt", 64'(wr_count_o), 64'(exp_b.cnt));
            chk("beat_map", 64'(wr_sparsemap_o), 64'(exp_b.map));
            chk("beat_data", wr_nonzero_data_o, exp_b.data);
          end
        end else begin
          stall_prev = 1'b1;
          held.cnt   = wr_count_o;
          held.map   = wr_sparsemap_o;
          held.data  = wr_nonzero_data_o;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int nnz_m, first_v, ovr0;
    bit seen;
    fill(v.pat, v.bufi);
    push_expect(v.bufi, v.sh, nnz_m);
    ovr0    = ovr_cnt;
    first_v = -1;
    seen    = 1'b0;
    @(negedge clk_r);
    start_i   = 1'b1;
    buf_idx_i = v.bufi;
    shift_i   = v.sh;
    @(posedge clk_r);
    for (int n = 0; n < 400 && !seen; n++) begin
      #1;
      start_i    = v.ovr && (n == 10 || n == v.exp_done);
      buf_idx_i  = ~v.bufi;
      shift_i    = 5'd0;
      wr_ready_i = !(v.stall_beat >= 0 && n >= CU+1+v.stall_beat &&
                     n < CU+1+v.stall_beat+v.stall_len);
      @(negedge clk_r);
      if (n == 0 || n == CU-1) chk("cu_sel", 64'(cu_sel_o), 64'(n));
      if (n == 0) chk("busy", 64'(busy_o), 64'd1);
      if (n == 20) chk("obuf_sel", 64'(obuf_sel_o), 64'(v.bufi));
      if (v.ovr && (n == 10 || n == v.exp_done)) chk("overrun", 64'(overrun_o), 64'd1);
      if (wr_valid_o && first_v < 0) begin
        first_v = n;
        chk("first_valid_cyc", 64'(n), 64'(CU+1));
        if (v.chk_map0) chk("map0", 64'(wr_sparsemap_o), 64'(v.exp_map0));
      end
      if (done_o) begin
        seen = 1'b1;
        chk("done_cyc", 64'(n), 64'(v.exp_done));
        chk("nnz", 64'(nnz_count_o), 64'(nnz_m));
        if (v.exp_nnz >= 0) chk("nnz_const", 64'(nnz_count_o), 64'(v.exp_nnz));
      end
      @(posedge clk_r);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o expected cycle %0d", v.exp_done);
    end
    #1;
    start_i    = 1'b0;
    wr_ready_i = 1'b1;
    @(negedge clk_r);
    chk("idle_after", 64'(busy_o), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("overrun_count", 64'(ovr_cnt - ovr0), v.ovr ? 64'd2 : 64'd0);
    sb_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cu_sel"}, 64'(cu_sel_o), 64'd0);
    chk({tag, "_obuf_sel"}, 64'(obuf_sel_o), 64'd0);
    chk({tag, "_valid"}, 64'(wr_valid_o), 64'd0);
    chk({tag, "_count"}, 64'(wr_count_o), 64'd0);
    chk({tag, "_map"}, 64'(wr_sparsemap_o), 64'd0);
    chk({tag, "_data"}, wr_nonzero_data_o, 64'd0);
    chk({tag, "_nnz"}, 64'(nnz_count_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun_o), 64'd0);
  endtask

  initial begin
    int bad, dummy;
    vecs[0] = '{0, 2'd0, 5'd0,  -1, 0, 1'b0, 32, 36, 1'b1, 8'hFF};
    vecs[1] = '{1, 2'd1, 5'd2,  -1, 0, 1'b0, 16, 36, 1'b1, 8'h55};
    vecs[2] = '{2, 2'd2, 5'd0,  -1, 0, 1'b0,  1, 36, 1'b1, 8'h00};
    vecs[3] = '{3, 2'd3, 5'd3,   1, 5, 1'b0, -1, 41, 1'b0, 8'h00};
    vecs[4] = '{1, 2'd0, 5'd2,  -1, 0, 1'b1, 16, 36, 1'b1, 8'h55};
    vecs[5] = '{4, 2'd1, 5'd31, -1, 0, 1'b0,  0, 36, 1'b1, 8'h00};
    vecs[6] = '{5, 2'd2, 5'd0,  -1, 0, 1'b0, 20, 36, 1'b1, 8'hA7};

    rst_r      = 1'b0;
    start_i    = 1'b0;
    wr_ready_i = 1'b1;
    buf_idx_i  = 2'd0;
    shift_i    = 5'd0;
    fill(0, 2'd0);
    repeat (3) @(posedge clk_r);
    @(negedge clk_r);
    chk_reset_vals("rst");
    rst_r = 1'b1;
    @(negedge clk_r);
    chk_reset_vals("post_rst");

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of READ: everything back to reset values, no stray beats.
    fill(0, 2'd3);
    push_expect(2'd3, 5'd0, dummy);
    @(negedge clk_r);
    start_i   = 1'b1;
    buf_idx_i = 2'd3;
    @(posedge clk_r);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk_r);
    #1 rst_r = 1'b0;
    sb_q.delete();
    @(negedge clk_r);
    chk_reset_vals("midrst");
    @(posedge clk_r);
    #1 rst_r = 1'b1;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_r);
      if (wr_valid_o || done_o || busy_o) bad++;
    end
    chk("no_activity_after_rst", 64'(bad), 64'd0);

    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
